// File: rtl/tdm_defs.sv
// Shared definitions for the TDM link (tdm_mux transmitter and tdm_demux receiver):
// state encodings, slot-count legality and select-width derivation.
package tdm_defs;

  typedef enum logic {
    HUNT = 1'b0,
    RUN  = 1'b1
  } tdm_state_t;

  localparam int TDM_MIN_SLOTS = 2;
  localparam int TDM_MAX_SLOTS = 16;

  function automatic bit tdm_slots_legal(input int n);
    return (n >= TDM_MIN_SLOTS) && (n <= TDM_MAX_SLOTS);
  endfunction

  // Width of a slot index; never below one bit so a select port always exists.
  function automatic int tdm_sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tdm_slot_counter.sv
// Slot index counter for the TDM receiver: advances on each valid sample,
// wraps after the last slot, and can be reloaded to 1 (resync) or cleared.
module tdm_slot_counter
  import tdm_defs::*;
#(
  parameter  int N_SLOTS = 4,
  localparam int SW      = tdm_sel_width(N_SLOTS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic          load,
  input  logic          clear,
  output logic [SW-1:0] sel,
  output logic          last
);

  localparam logic [SW-1:0] LAST_SEL = SW'(N_SLOTS - 1);

  // clear beats load beats normal advance; nothing moves without enable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel <= '0;
    end else if (enable) begin
      if (clear) begin
        sel <= '0;
      end else if (load) begin
        sel <= SW'(1);
      end else if (sel == LAST_SEL) begin
        sel <= '0;
      end else begin
        sel <= sel + SW'(1);
      end
    end
  end

  assign last = (sel == LAST_SEL);

endmodule

// File: rtl/tdm_demux.sv
// Time-division demultiplexer: aligns to slot 0 on Sync, assembles N_SLOTS samples
// into a parallel frame. Optional alignment-error reporting with TDM_DEMUX_ERR_EN.
module tdm_demux
  import tdm_defs::*;
#(
  parameter  int N_SLOTS = 4,
  parameter  int W       = 8,
  localparam int SW      = tdm_sel_width(N_SLOTS)
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic [W-1:0]         Din,
  input  logic                 Din_valid,
  input  logic                 Sync,
  output logic [N_SLOTS*W-1:0] Y,
  output logic                 Frame_valid,
  output logic [SW-1:0]        Sel
`ifdef TDM_DEMUX_ERR_EN
  ,
  output logic                 Err
`endif
);

  generate
    if (!tdm_slots_legal(N_SLOTS)) begin : g_bad_slots
      $error("tdm_demux: N_SLOTS out of range 2..16");
    end
  endgenerate

`ifdef TDM_DEMUX_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  tdm_state_t           state;
  logic [W-1:0]         shadow [N_SLOTS];
  logic [N_SLOTS*W-1:0] frame_next;
  logic                 sel_last;
  logic                 hunt_lock;
  logic                 early_sync;
  logic                 missing_sync;
  logic                 drop_sample;
  logic                 ctr_load;
  logic                 ctr_clear;

  always_comb begin
    hunt_lock    = (state == HUNT) && Din_valid && Sync;
    early_sync   = (state == RUN) && Din_valid && Sync && (Sel != '0);
    missing_sync = (state == RUN) && Din_valid && !Sync && (Sel == '0);
    drop_sample  = ERR_EN && missing_sync;
    ctr_load     = hunt_lock || early_sync;
    ctr_clear    = ((state == HUNT) && !Sync) || drop_sample;
  end

  tdm_slot_counter #(
    .N_SLOTS(N_SLOTS)
  ) u_slot_counter (
    .clk   (Clk),
    .reset (Reset),
    .enable(Din_valid),
    .load  (ctr_load),
    .clear (ctr_clear),
    .sel   (Sel),
    .last  (sel_last)
  );

  // The last slot bypasses its shadow so Y can update on the same edge it is sampled.
  always_comb begin
    frame_next = '0;
    for (int k = 0; k < N_SLOTS - 1; k++) begin
      frame_next[k*W +: W] = shadow[k];
    end
    frame_next[(N_SLOTS-1)*W +: W] = Din;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state       <= HUNT;
      Y           <= '0;
      Frame_valid <= 1'b0;
      for (int k = 0; k < N_SLOTS; k++) begin
        shadow[k] <= '0;
      end
`ifdef TDM_DEMUX_ERR_EN
      Err         <= 1'b0;
`endif
    end else begin
      Frame_valid <= 1'b0;
`ifdef TDM_DEMUX_ERR_EN
      Err         <= early_sync || missing_sync;
`endif
      if (Din_valid) begin
        case (state)
          HUNT: begin
            if (Sync) begin
              shadow[0] <= Din;
              state     <= RUN;
            end
          end
          RUN: begin
            if (early_sync) begin
              shadow[0] <= Din;
            end else if (drop_sample) begin
              state <= HUNT;
            end else begin
              shadow[Sel] <= Din;
              if (sel_last) begin
                Y           <= frame_next;
                Frame_valid <= 1'b1;
              end
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

endmodule

// File: doc/tdm_demux.md
# tdm_demux

Time-division demultiplexer: the receive end of the slotted link driven by the `mux` select-rotation scheme. It accepts one W-bit sample per valid cycle on a shared line, and uses a frame sync marker to align to slot 0. It assembles N_SLOTS consecutive samples into a frame and presents all channels in parallel with a one-cycle frame strobe. It sits between the serial link and the per-channel consumers.

## Interface
- N_SLOTS, 4, number of channels per frame; legal range 2..16
- W, 8, sample width in bits
- SW, derived localparam, $clog2(N_SLOTS)
- Clk  input  1  rising-edge clock; the only clock
- Reset  input  1  asynchronous, active-high reset
- Din  input  W  sample on the shared line
- Din_valid  input  1  Din carries a sample this cycle
- Sync  input  1  qualifies the current sample as slot 0; ignored when Din_valid=0
- Y  output  N_SLOTS*W  assembled frame; slot k occupies bits [k*W +: W]
- Frame_valid  output  1  one-cycle pulse when Y updates
- Sel  output  SW  slot index the next valid sample will be written to
- Err  output  1  one-cycle alignment-error pulse (present only with TDM_DEMUX_ERR_EN)

## Operation
- States: HUNT and RUN.
- HUNT:
  - Samples are discarded unless Din_valid=1 and Sync=1.
  - On such a sample: store it in shadow[0], set Sel=1, go to RUN.
- RUN: on each cycle with Din_valid=1, the sample is written to shadow[Sel], then:
  - Sel<N_SLOTS-1: Sel increments.
  - Sel=N_SLOTS-1: the complete frame, including the current Din, is copied to Y. Frame_valid pulses, Sel wraps to 0, state stays RUN.
  - Sync=1 with Sel=0: normal frame start.
  - Sync=1 with Sel≠0 (early sync):
    - The partial frame is dropped and Y is not updated.
    - The sample is taken as slot 0 and Sel becomes 1.
    - Err pulses when the macro is defined.
  - Sync=0 with Sel=0 (missing sync): behaviour depends on configuration.
- Din_valid=0: no state change at all. This is a stall, and any number of stall cycles may occur inside a frame.
- Shadow registers are not cleared between frames. Y holds its value between Frame_valid pulses.

## Timing
- All outputs are registered, and all update on the Clk edge that samples the qualifying input.
- Latency: Y and Frame_valid become valid in the cycle after the edge that samples slot N_SLOTS-1, and Frame_valid is high for exactly that cycle.
- Back-to-back frames with no stalls give Frame_valid once every N_SLOTS cycles.
- Simultaneous events:
  - Last-slot sample with Sync=1 is treated as an early sync: drop, resync, no Frame_valid.
  - For N_SLOTS=2 this means the sample at Sel=1 is never the sync.
- Reset (asynchronous, any cycle, including mid-frame):
  - State=HUNT, Sel=0.
  - Y=0, Frame_valid=0, Err=0, all shadow registers 0.
  - The first frame after reset requires a fresh Sync.

## Configuration
- Macro: TDM_DEMUX_ERR_EN.
- Defined:
  - The Err port exists.
  - Missing sync at Sel=0 in RUN: Err pulses, the sample is discarded, state goes to HUNT.
  - Early sync pulses Err.
- Undefined:
  - The Err port is absent.
  - Missing sync at Sel=0 is accepted as a normal slot 0, i.e. free-running after the first lock.
  - Early sync still resyncs, silently.

## Structure
- Shared package/header tdm_defs: HUNT/RUN state encodings, the N_SLOTS legality check and the SW derivation. The tdm_mux transmitter uses the same definitions.
- One sub-module, tdm_slot_counter:
  - Inputs: Clk, Reset, enable (= Din_valid), load-to-1 (= resync), clear.
  - Outputs: Sel and a last-slot flag.
- Shadow registers, the Y copy and the FSM live in tdm_demux.

## Test plan
All scenarios use N_SLOTS=4, W=8.
- Reset then Sync on 8'h11, followed by 8'h22, 8'h33, 8'h44 with no stalls:
  - Y=32'h44332211 and Frame_valid=1 exactly one cycle after 8'h44 is sampled.
  - Sel goes 1, 2, 3, 0.
- Same frame with Din_valid low for 3 cycles between slots 1 and 2 -> identical Y, with Frame_valid delayed by 3 cycles.
- In RUN, Sync arrives at Sel=2 on 8'hAA, followed by 8'hBB, 8'hCC, 8'hDD:
  - No Frame_valid for the aborted frame.
  - Next Y=32'hDDCCBBAA.
  - Err pulses once at the resync (macro on).
- Sync=0 at Sel=0 with the macro on -> Err pulse, state HUNT, Y unchanged until the next Sync. With the macro off, the frame assembles normally.
- Samples before any Sync in HUNT (8'hFF ×5) -> Sel=0 and no Frame_valid.
- Reset asserted asynchronously mid-frame at Sel=2:
  - Y=0, Frame_valid=0, Sel=0 immediately.
  - After release, the next frame completes only after a Sync.
